// File: rtl/shift_right_arith.sv
// -----------------------------------------------------------------------------
// shift_right_arith
//
// Registered arithmetic right shifter with a shift amount fixed at elaboration
// time. It is used for SRAI-style constant shifts in the RV32 datapath.
//
// The operand is shifted right by SHAMT bit positions. Each vacated MSB gets a
// copy of the operand's sign bit. The shifter is built in barrel form: there
// are log2(WIDTH) mux stages, and stage s moves the value right by 2**s
// positions when bit s of SHAMT is set. The result is registered, so the
// latency is one cycle. A new operand can be accepted on every cycle.
//
// Parameters
//   SHAMT     constant shift amount, legal range 0..WIDTH-1
//   WIDTH     operand/result width, a power of two and >= 2
//
// Ports
//   clk_i     in   1      clock; all state changes on the rising edge
//   rst_i     in   1      synchronous reset, active-high; wins over valid_i
//   valid_i   in   1      qualifies data_i; data is captured only when 1
//   data_i    in   WIDTH  operand, two's complement
//   result_o  out  WIDTH  registered $signed(data_i) >>> SHAMT
//   valid_o   out  1      high for one cycle for each captured operand
//   sticky_o  out  1      OR of the bits shifted out of the captured operand
//
// Build option
//   SRA_STICKY_EN  If this macro is defined, sticky_o is registered alongside
//                  result_o for the downstream rounding logic. If it is not
//                  defined, sticky_o is tied to 0 and no sticky logic is built.
// -----------------------------------------------------------------------------
module shift_right_arith #(
    parameter int SHAMT = 5,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             sticky_o
);

    localparam int STAGES = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("shift_right_arith: WIDTH=%0d must be a power of two >= 2", WIDTH);
        end
        if (SHAMT < 0 || SHAMT >= WIDTH) begin : g_bad_shamt
            $error("shift_right_arith: SHAMT=%0d out of range 0..%0d", SHAMT, WIDTH - 1);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Barrel network
    // stage[0] is the raw operand and stage[STAGES] is the fully shifted value.
    // Each stage is either a fixed sign-filling shift or a plain pass-through,
    // chosen when the design is elaborated. A constant shift therefore reduces
    // to wiring after synthesis. The stages are kept so the structure matches
    // the variable-shift barrel found elsewhere in the datapath.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] stage [STAGES+1];

    // NOTE: continuous assigns with one driver per net cannot infer latches,
    // unlike an always block that leaves a path unassigned.
    assign stage[0] = data_i;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            localparam int STEP = 1 << s;
            if (((SHAMT >> s) % 2) == 1) begin : g_shift
                assign stage[s+1] = {{STEP{stage[s][WIDTH-1]}},
                                     stage[s][WIDTH-1:STEP]};
            end else begin : g_pass
                assign stage[s+1] = stage[s];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples its inputs before any of them update, so the result does
    // not depend on the order of the statements.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the data register is reset as well as the valid flag,
            // because result_o must read exactly 0 after reset and not
            // just be marked invalid.
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                result_o <= stage[STAGES];
            end
        end
    end

`ifdef SRA_STICKY_EN
    // Mask of the bit positions that are shifted out. It is zero when
    // SHAMT = 0, which keeps sticky_o at 0 without a separate SHAMT = 0 case.
    localparam logic [WIDTH-1:0] STICKY_MASK =
        (WIDTH'(1) << SHAMT) - WIDTH'(1);

    logic sticky_next;
    assign sticky_next = |(data_i & STICKY_MASK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_o <= 1'b0;
        end else if (valid_i) begin
            sticky_o <= sticky_next;
        end
    end
`else
    assign sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_right_arith.sv
// -----------------------------------------------------------------------------
// tb_shift_right_arith
//
// Directed self-checking bench for shift_right_arith with SHAMT=5, WIDTH=32.
// Expected results are hand-computed constants, plus a small reference model
// ($signed >>> 5) for the block of random operands. The expected sticky value
// follows the SRA_STICKY_EN build option.
// -----------------------------------------------------------------------------
module tb_shift_right_arith;

    localparam int SHAMT = 5;
    localparam int WIDTH = 32;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             sticky_o;

    int total_cnt;
    int bad_cnt;

    shift_right_arith #(
        .SHAMT (SHAMT),
        .WIDTH (WIDTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .result_o (result_o),
        .valid_o  (valid_o),
        .sticky_o (sticky_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One comparison: count it, and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then wait 1 time unit so outputs are sampled
    // away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected sticky bit for an operand in this build.
    function automatic logic exp_sticky(input logic [31:0] d);
`ifdef SRA_STICKY_EN
        return |d[SHAMT-1:0];
`else
        return 1'b0;
`endif
    endfunction

    // Present one valid operand and check the registered result.
    task automatic push_check(input string tag, input logic [31:0] d,
                              input logic [31:0] exp_res);
        valid_i = 1'b1;
        data_i  = d;
        tick();
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_vld"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_stk"}, {31'd0, sticky_o}, {31'd0, exp_sticky(d)});
    endtask

    // Directed vectors: operand and hand-computed result for >>> 5.
    logic [31:0] vec_in  [10];
    logic [31:0] vec_exp [10];

    initial begin
        logic [31:0]        d;
        logic signed [31:0] ds;
        logic [31:0]        last_res;
        logic               last_stk;

        total_cnt = 0;
        bad_cnt   = 0;

        vec_in[0] = 32'h0000_0000; vec_exp[0] = 32'h0000_0000;
        vec_in[1] = 32'h000F_423F; vec_exp[1] = 32'h0000_7A11;
        vec_in[2] = 32'h8000_0000; vec_exp[2] = 32'hFC00_0000;
        vec_in[3] = 32'hFFFF_FFFF; vec_exp[3] = 32'hFFFF_FFFF;
        vec_in[4] = 32'h7FFF_FFFF; vec_exp[4] = 32'h03FF_FFFF;
        vec_in[5] = 32'h0000_001F; vec_exp[5] = 32'h0000_0000;
        vec_in[6] = 32'h0000_0020; vec_exp[6] = 32'h0000_0001;
        vec_in[7] = 32'h1234_5678; vec_exp[7] = 32'h0091_A2B3;
        vec_in[8] = 32'hDEAD_BEEF; vec_exp[8] = 32'hFEF5_6DF7;
        vec_in[9] = 32'hFFFF_FFE0; vec_exp[9] = 32'hFFFF_FFFF;

        // Reset for 2 cycles with valid_i held high; the reset must win.
        rst_i   = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_res", result_o, 32'h0);
            check("rst_vld", {31'd0, valid_o}, 32'd0);
            check("rst_stk", {31'd0, sticky_o}, 32'd0);
        end
        rst_i = 1'b0;

        // Directed vectors, fed back-to-back one per cycle.
        for (int i = 0; i < 10; i++) begin
            push_check($sformatf("vec%0d", i), vec_in[i], vec_exp[i]);
        end

        // Idle cycles: valid_o drops, result and sticky hold their last values.
        last_res = vec_exp[9];
        last_stk = exp_sticky(vec_in[9]);
        valid_i  = 1'b0;
        data_i   = 32'h0000_0FFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_res", result_o, last_res);
            check("idle_vld", {31'd0, valid_o}, 32'd0);
            check("idle_stk", {31'd0, sticky_o}, {31'd0, last_stk});
        end

        // Three back-to-back operands, checked in order.
        push_check("b2b0", 32'h0000_0040, 32'h0000_0002);
        push_check("b2b1", 32'hFFFF_FFC1, 32'hFFFF_FFFE);
        push_check("b2b2", 32'h4000_0000, 32'h0200_0000);

        // Reset arriving mid-stream, after a valid capture.
        push_check("pre_rst", 32'h7FFF_FFFF, 32'h03FF_FFFF);
        rst_i   = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h8000_0001;
        tick();
        check("mid_rst_res", result_o, 32'h0);
        check("mid_rst_vld", {31'd0, valid_o}, 32'd0);
        check("mid_rst_stk", {31'd0, sticky_o}, 32'd0);
        rst_i = 1'b0;
        push_check("post_rst", 32'h8000_0001, 32'hFC00_0000);

        // Random operands against the reference model.
        for (int i = 0; i < 1000; i++) begin
            d  = $urandom;
            ds = d;
            push_check("rand", d, 32'(ds >>> SHAMT));
        end

        valid_i = 1'b0;
        tick();
        check("final_vld", {31'd0, valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
